// File: rtl/packet_hex_framer.sv
// packet_hex_framer
// Captures a packet word on a load strobe and streams it out as uppercase
// ASCII hex characters (most-significant nibble first), one character per
// valid/ready handshake, followed by a terminator byte. Loads that arrive
// while a frame is in flight are dropped and counted in a saturating counter.

module packet_hex_framer #(
  parameter int          PACKET_SIZE   = 512,
  parameter logic [7:0]  TERMINATOR    = 8'h0D,
  parameter int          OVERRUN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_SIZE-1:0]   packet,
  input  logic                     load,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [OVERRUN_WIDTH-1:0] overrun
);

  localparam int TOTAL_NIBBLES = PACKET_SIZE / 4;
  localparam int IDX_W         = (TOTAL_NIBBLES > 1) ? $clog2(TOTAL_NIBBLES) : 1;

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(TOTAL_NIBBLES - 1);
  localparam logic [IDX_W-1:0]         ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]         ONE_IDX  = IDX_W'(1);
  localparam logic [OVERRUN_WIDTH-1:0] OVR_MAX  = {OVERRUN_WIDTH{1'b1}};
  localparam logic [OVERRUN_WIDTH-1:0] OVR_ONE  = OVERRUN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NIBBLE = 2'd1,
    TERM   = 2'd2
  } state_t;

  // Uppercase ASCII hex digit for a 4-bit value ('A' - 10 = 8'h37).
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = 8'h37 + {4'h0, n};
    end
    return c;
  endfunction

  state_t                   state_q,    state_d;
  logic [IDX_W-1:0]         idx_q,      idx_d;
  logic [PACKET_SIZE-1:0]   shadow_q,   shadow_d;
  logic [7:0]               tx_data_q,  tx_data_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     busy_q,     busy_d;
  logic [OVERRUN_WIDTH-1:0] overrun_q,  overrun_d;

  logic                     hs_s;
  logic [IDX_W-1:0]         next_idx_s;
  logic [3:0]               next_nib_s;
  logic [3:0]               first_nib_s;

  assign hs_s        = tx_valid_q & tx_ready;
  assign next_idx_s  = idx_q - ONE_IDX;
  assign next_nib_s  = shadow_q[{next_idx_s, 2'b00} +: 4];
  assign first_nib_s = packet[PACKET_SIZE-1 -: 4];

  // Next-state logic: frame sequencing, character preparation and overrun counting.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;

    // A load seen while busy (including the terminator handshake cycle) is dropped.
    if (load && busy_q && (overrun_q != OVR_MAX)) begin
      overrun_d = overrun_q + OVR_ONE;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          shadow_d   = packet;
          idx_d      = LAST_IDX;
          tx_data_d  = hex_ascii(first_nib_s);
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = NIBBLE;
        end else begin
          state_d    = IDLE;
        end
      end
      NIBBLE: begin
        // The following character is prepared on the handshake so a
        // continuously ready sink sees one byte per cycle with no bubble.
        if (hs_s) begin
          if (idx_q == ZERO_IDX) begin
            tx_data_d = TERMINATOR;
            state_d   = TERM;
          end else begin
            idx_d     = next_idx_s;
            tx_data_d = hex_ascii(next_nib_s);
          end
        end else begin
          state_d = NIBBLE;
        end
      end
      TERM: begin
        if (hs_s) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d    = TERM;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        idx_d      = ZERO_IDX;
        state_d    = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= ZERO_IDX;
      shadow_q   <= {PACKET_SIZE{1'b0}};
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= {OVERRUN_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_packet_hex_framer.sv
// Self-checking bench for packet_hex_framer (PACKET_SIZE=16). A frame-level
// reference model builds the expected character stream from each accepted
// packet and tracks dropped loads; test tasks compare the observed stream.

module tb_packet_hex_framer;

  localparam int PS = 16;
  localparam int NN = PS / 4;
  localparam int OVR_SAT = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [PS-1:0] packet;
  logic          load;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic [7:0]    overrun;

  packet_hex_framer #(.PACKET_SIZE(PS), .TERMINATOR(8'h0D), .OVERRUN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .packet(packet), .load(load),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model and observation state
  logic [7:0] m_frame[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] obs_bytes[$];
  int         obs_cyc[$];
  int         m_ovr;
  int         cyc;
  int         valid_cycles;
  int         hold_viol;
  logic       prev_valid;
  logic       prev_ready;
  logic [7:0] prev_data;

  logic [7:0] lit_1a2f[5];
  logic [7:0] lit_0009[5];

  function automatic logic [7:0] to_hex(input int n);
    if (n < 10) return 8'(48 + n);
    else        return 8'(65 + n - 10);
  endfunction

  task automatic clear_model();
    m_frame.delete(); exp_bytes.delete(); obs_bytes.delete(); obs_cyc.delete();
    m_ovr = 0; valid_cycles = 0; hold_viol = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00;
  endtask

  // one clock: drive inputs at the falling edge, record what the DUT shows,
  // and advance the frame-level model
  task automatic tick(input logic ld, input logic [PS-1:0] pkt, input logic rdy);
    bit model_busy;
    @(negedge clk);
    cyc++;
    if (prev_valid && !prev_ready && (tx_valid !== 1'b1 || tx_data !== prev_data)) hold_viol++;
    load = ld; packet = pkt; tx_ready = rdy;
    if (tx_valid === 1'b1) valid_cycles++;
    if (tx_valid === 1'b1 && rdy) begin
      obs_bytes.push_back(tx_data);
      obs_cyc.push_back(cyc);
    end
    model_busy = (m_frame.size() != 0);
    if (model_busy && rdy) exp_bytes.push_back(m_frame.pop_front());
    if (ld) begin
      if (model_busy) begin
        if (m_ovr < OVR_SAT) m_ovr++;
      end else begin
        for (int i = NN - 1; i >= 0; i--) m_frame.push_back(to_hex((int'(pkt) >> (4 * i)) & 15));
        m_frame.push_back(8'h0D);
      end
    end
    prev_valid = tx_valid; prev_ready = rdy; prev_data = tx_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; load = 1'b0; tx_ready = 1'b0; packet = '0;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; load = 1'b0; tx_ready = 1'b0; packet = '0;
    #1;
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (overrun !== 8'h00) begin n_fail++; $display("FAIL reset_overrun got=%h exp=00", overrun); end
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_basic();
    int l;
    do_reset();
    tick(1'b1, 16'h1A2F, 1'b1);
    l = cyc;
    for (int i = 0; i < 6; i++) tick(1'b0, 16'h0000, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    n_cmp++; if (obs_bytes.size() != 5) begin n_fail++; $display("FAIL basic_len got=%0d exp=5", obs_bytes.size()); end
    for (int i = 0; i < obs_bytes.size() && i < 5; i++) begin
      n_cmp++; if (obs_bytes[i] !== lit_1a2f[i] || obs_bytes[i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL basic_byte%0d got=%h exp=%h", i, obs_bytes[i], lit_1a2f[i]); end
      n_cmp++; if (obs_cyc[i] != l + 1 + i) begin
        n_fail++; $display("FAIL basic_timing%0d got=%0d exp=%0d", i, obs_cyc[i] - l, 1 + i); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(1'b1, 16'h1A2F, 1'b0);
    valid_cycles = 0;
    for (int i = 0; i < 15; i++) tick(1'b0, $urandom, (i % 3) == 2);
    n_cmp++; if (valid_cycles != 15) begin n_fail++; $display("FAIL bp_valid_cycles got=%0d exp=15", valid_cycles); end
    tick(1'b0, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    n_cmp++; if (valid_cycles != 15) begin n_fail++; $display("FAIL bp_valid_after got=%0d exp=15", valid_cycles); end
    n_cmp++; if (hold_viol != 0) begin n_fail++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
    n_cmp++; if (obs_bytes.size() != 5) begin n_fail++; $display("FAIL bp_len got=%0d exp=5", obs_bytes.size()); end
    for (int i = 0; i < obs_bytes.size() && i < 5; i++) begin
      n_cmp++; if (obs_bytes[i] !== lit_1a2f[i] || obs_bytes[i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL bp_byte%0d got=%h exp=%h", i, obs_bytes[i], lit_1a2f[i]); end
    end
  endtask

  task automatic test_load_while_busy();
    do_reset();
    tick(1'b1, 16'h1A2F, 1'b0);
    tick(1'b1, 16'hFFFF, 1'b0);
    tick(1'b0, 16'hFFFF, 1'b1);
    tick(1'b1, 16'hFFFF, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 16'hFFFF, 1'b1);
    n_cmp++; if (overrun !== 8'd2 || m_ovr != 2) begin n_fail++; $display("FAIL lwb_overrun got=%0d exp=2", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lwb_busy got=%b exp=0", busy); end
    n_cmp++; if (obs_bytes.size() != 5) begin n_fail++; $display("FAIL lwb_len got=%0d exp=5", obs_bytes.size()); end
    for (int i = 0; i < obs_bytes.size() && i < 5; i++) begin
      n_cmp++; if (obs_bytes[i] !== lit_1a2f[i] || obs_bytes[i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL lwb_byte%0d got=%h exp=%h", i, obs_bytes[i], lit_1a2f[i]); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    tick(1'b1, 16'h1A2F, 1'b0);
    for (int i = 0; i < 300; i++) tick(1'b1, 16'h5555, 1'b0);
    n_cmp++; if (overrun !== 8'hFF || m_ovr != OVR_SAT) begin n_fail++; $display("FAIL sat_overrun got=%h exp=ff", overrun); end
    for (int i = 0; i < 8; i++) tick(1'b0, 16'h0000, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_idle got=%b exp=0", busy); end
    tick(1'b1, 16'hBEEF, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sat_accept got=%b exp=1", busy); end
    n_cmp++; if (overrun !== 8'hFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ff", overrun); end
    for (int i = 0; i < 8; i++) tick(1'b0, 16'h0000, 1'b1);
    n_cmp++; if (obs_bytes.size() != exp_bytes.size() || obs_bytes.size() != 10) begin
      n_fail++; $display("FAIL sat_len got=%0d exp=10", obs_bytes.size()); end
    for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++) begin
      n_cmp++; if (obs_bytes[i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL sat_byte%0d got=%h exp=%h", i, obs_bytes[i], exp_bytes[i]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 16'h1A2F, 1'b1);
    tick(1'b1, 16'hFFFF, 1'b1);
    tick(1'b0, 16'h0000, 1'b1);
    @(posedge clk);
    #2;
    n_cmp++; if (overrun !== 8'd1) begin n_fail++; $display("FAIL ar_pre_overrun got=%0d exp=1", overrun); end
    reset = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ar_tx_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got=%b exp=0", busy); end
    n_cmp++; if (overrun !== 8'h00) begin n_fail++; $display("FAIL ar_overrun got=%h exp=00", overrun); end
    @(negedge clk);
    reset = 1'b0; load = 1'b0; tx_ready = 1'b0;
    clear_model();
    tick(1'b1, 16'h0009, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 16'h0000, 1'b1);
    n_cmp++; if (obs_bytes.size() != 5) begin n_fail++; $display("FAIL ar_len got=%0d exp=5", obs_bytes.size()); end
    for (int i = 0; i < obs_bytes.size() && i < 5; i++) begin
      n_cmp++; if (obs_bytes[i] !== lit_0009[i] || obs_bytes[i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL ar_byte%0d got=%h exp=%h", i, obs_bytes[i], lit_0009[i]); end
    end
  endtask

  task automatic test_load_on_term();
    do_reset();
    tick(1'b1, 16'h1A2F, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0000, 1'b1);
    tick(1'b1, 16'h2222, 1'b1);
    tick(1'b0, 16'h0000, 1'b0);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lot_busy got=%b exp=0", busy); end
    n_cmp++; if (overrun !== 8'd1 || m_ovr != 1) begin n_fail++; $display("FAIL lot_overrun got=%0d exp=1", overrun); end
    tick(1'b1, 16'h00C3, 1'b1);
    tick(1'b0, 16'h0000, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lot_accept got=%b exp=1", busy); end
    for (int i = 0; i < 6; i++) tick(1'b0, 16'h0000, 1'b1);
    n_cmp++; if (obs_bytes.size() != exp_bytes.size() || obs_bytes.size() != 10) begin
      n_fail++; $display("FAIL lot_len got=%0d exp=10", obs_bytes.size()); end
    for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++) begin
      n_cmp++; if (obs_bytes[i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL lot_byte%0d got=%h exp=%h", i, obs_bytes[i], exp_bytes[i]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 7) == 0, PS'($urandom), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 12; i++) tick(1'b0, PS'($urandom), 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy got=%b exp=0", busy); end
    n_cmp++; if (overrun !== 8'(m_ovr)) begin n_fail++; $display("FAIL rnd_overrun got=%0d exp=%0d", overrun, m_ovr); end
    n_cmp++; if (hold_viol != 0) begin n_fail++; $display("FAIL rnd_hold got=%0d exp=0", hold_viol); end
    n_cmp++; if (obs_bytes.size() != exp_bytes.size()) begin
      n_fail++; $display("FAIL rnd_len got=%0d exp=%0d", obs_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++) begin
      n_cmp++; if (obs_bytes[i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL rnd_byte%0d got=%h exp=%h", i, obs_bytes[i], exp_bytes[i]); end
    end
  endtask

  initial begin
    lit_1a2f[0] = 8'h31; lit_1a2f[1] = 8'h41; lit_1a2f[2] = 8'h32; lit_1a2f[3] = 8'h46; lit_1a2f[4] = 8'h0D;
    lit_0009[0] = 8'h30; lit_0009[1] = 8'h30; lit_0009[2] = 8'h30; lit_0009[3] = 8'h39; lit_0009[4] = 8'h0D;
    cyc = 0;
    reset = 1'b1; load = 1'b0; tx_ready = 1'b0; packet = '0;
    clear_model();
    test_reset();
    test_basic();
    test_backpressure();
    test_load_while_busy();
    test_saturate();
    test_async_reset();
    test_load_on_term();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
